mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 8:1 single-bit multiplexer between eight requesters. It drives the mux select and enable lines.
- Each requester holds the mux for as long as its request stays high, up to a programmable hold limit. Ownership then rotates.
- Sits directly in front of the 8:1 mux: `sel` → mux `sel`, `en` → mux `EN`.
- Requester k drives mux data input ik.

---
 rtl/mux8_arb_pkg.sv | 12 +
 rtl/mux8_rr_pick.sv | 32 +++
 rtl/mux8_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux8_rr_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mux8_arb_pkg.sv
// Shared constants and types for the round-robin arbiter in front of the 8:1 mux.
package mux8_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux8_rr_pick.sv
// Combinational round-robin winner: first requester at or after ptr, wrapping mod 8.
module mux8_rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]     rot_idx;

    // Doubling the vector turns the rotate into a plain shift so bit 0 is requester ptr.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: NUM_REQ];
    assign any     = |req;

    always_comb begin
        rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = SEL_W'(i);
            end
        end
    end

    // 3-bit addition wraps naturally, undoing the rotation.
    assign idx = rot_idx + ptr;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving sel/en of an 8:1 mux, with a per-owner hold limit.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               busy
);

    localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic                release_now;
    logic [SEL_W-1:0]    pick_ptr;
    logic                pick_any;
    logic [SEL_W-1:0]    pick_idx;

    // On a release the winner is searched from owner+1, so the outgoing owner is last.
    assign pick_ptr = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;

    mux8_rr_pick u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign release_now = (state_q == GRANT) &&
                         (!req[sel_q] ||
                          (HOLD_LIMITED && (hold_cnt_q == HOLD_LAST)) ||
                          !arb_en);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        en_d       = en_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        if (state_q == IDLE) begin
            if (arb_en && pick_any) begin
                state_d    = GRANT;
                sel_d      = pick_idx;
                gnt_d      = NUM_REQ'(1) << pick_idx;
                en_d       = 1'b1;
                busy_d     = 1'b1;
                hold_cnt_d = '0;
            end
        end else if (!release_now) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
            ptr_d      = pick_ptr;
            hold_cnt_d = '0;
            if (arb_en && pick_any) begin
                sel_d = pick_idx;
                gnt_d = NUM_REQ'(1) << pick_idx;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign en   = en_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: hand-computed grants, plus invariants every cycle.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       arb_en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       en;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mux8_rr_arbiter #(.MAX_HOLD(16), .HOLD_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_en (arb_en),
        .req    (req),
        .gnt    (gnt),
        .sel    (sel),
        .en     (en),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s);
        chk({tag, "_gnt"}, gnt, g);
        chk({tag, "_sel"}, sel, s);
        chk({tag, "_en"}, en, (g != 8'h00));
        chk({tag, "_busy"}, busy, (g != 8'h00));
        $display("%-10s req=%02h arb_en=%0b gnt=%02h sel=%0d en=%0b busy=%0b",
                 tag, req, arb_en, gnt, sel, en, busy);
    endtask

    // Structural invariants sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("inv_onehot", $onehot0(gnt), 1);
            chk("inv_en", en, |gnt);
            chk("inv_busy", busy, en);
            if (en) chk("inv_gsel", gnt[sel], 1'b1);
        end
    end

    initial begin
        rst    = 1'b1;
        arb_en = 1'b1;
        req    = 8'h00;
        step();
        step();
        expect_out("reset", 8'h00, 3'd0);
        chk("reset_ptr", dut.ptr_q, 3'd0);
        chk("reset_hold", dut.hold_cnt_q, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("idle", 8'h00, 3'd0);
        end

        // Single requester 2 for three cycles, then dropped.
        req = 8'h04;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("single2", 8'h04, 3'd2);
        end
        req = 8'h00;
        step();
        expect_out("drop2", 8'h00, 3'd2);
        chk("drop2_ptr", dut.ptr_q, 3'd3);

        // Full contention from ptr=0: rotate every 16 cycles with no bubble.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 16; c++) begin
                chk("rot_gnt", gnt, 8'h01 << (k % 8));
                chk("rot_en", en, 1'b1);
                if (c == 0) expect_out("rot", 8'h01 << (k % 8), 3'(k % 8));
                step();
            end
        end
        req = 8'h00;
        step();
        expect_out("rot_end", 8'h00, 3'd1);
        chk("rot_end_ptr", dut.ptr_q, 3'd2);

        // Grant 4 then release, so ptr=5; requesters 0 and 4 -> 0 wins.
        req = 8'h10;
        step();
        expect_out("own4", 8'h10, 3'd4);
        req = 8'h00;
        step();
        chk("own4_ptr", dut.ptr_q, 3'd5);
        req = 8'h11;
        step();
        expect_out("wrap0", 8'h01, 3'd0);
        req = 8'h00;
        step();
        expect_out("wrap0_rel", 8'h00, 3'd0);

        // Lone requester 3 for 40 cycles: re-granted each hold period, no gap.
        req = 8'h08;
        step();
        for (int n = 0; n < 40; n++) begin
            chk("lone3_gnt", gnt, 8'h08);
            chk("lone3_hold", dut.hold_cnt_q, n % 16);
            if (n == 16 || n == 32) expect_out("lone3_re", 8'h08, 3'd3);
            step();
        end
        req = 8'h00;
        step();
        expect_out("lone3_rel", 8'h00, 3'd3);
        chk("lone3_ptr", dut.ptr_q, 3'd4);

        // Owner 1, then arb_en drops with 1 and 2 requesting.
        req = 8'h02;
        step();
        expect_out("own1", 8'h02, 3'd1);
        req    = 8'h06;
        arb_en = 1'b0;
        step();
        expect_out("arboff", 8'h00, 3'd1);
        chk("arboff_ptr", dut.ptr_q, 3'd2);
        step();
        expect_out("arboff2", 8'h00, 3'd1);
        chk("arboff2_ptr", dut.ptr_q, 3'd2);
        arb_en = 1'b1;
        step();
        expect_out("arbon", 8'h04, 3'd2);

        // Owner 2 drops while 1 still requests: direct handoff via wrap.
        req = 8'h02;
        step();
        expect_out("handoff", 8'h02, 3'd1);
        chk("handoff_ptr", dut.ptr_q, 3'd3);
        chk("handoff_hold", dut.hold_cnt_q, 0);

        // Reset in the middle of a grant.
        step();
        rst = 1'b1;
        step();
        expect_out("midrst", 8'h00, 3'd0);
        chk("midrst_ptr", dut.ptr_q, 3'd0);
        rst = 1'b0;
        req = 8'h00;
        step();
        expect_out("post_rst", 8'h00, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
